sample_sdiv_seq: RTL and testbench

Sequential signed integer divider, the inverse operation of the team's truncating signed multiplier. It computes quotient and remainder of WIDTH-bit two's-complement operands with a one-bit-per-cycle restoring algorithm. The divide is truncating, rounding toward zero. It sits beside the multiplier in the HLS-generated datapath and is driven by an ap_start/ap_done/ap_idle/ap_ready block-level handshake.

---
 rtl/sample_sdiv_pkg.sv | 21 ++
 rtl/sample_sdiv_seq_step.sv | 18 +
 rtl/sample_sdiv_seq.sv | 108 ++++++++++
 tb/tb_sample_sdiv_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_sdiv_pkg.sv
// sample_sdiv_pkg: shared FSM states, flag bit positions and counter-width helper
// for the sequential signed divider.
package sample_sdiv_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_DBZ = 0;
    localparam int FLAG_OVF = 1;
    localparam int NFLAGS   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/sample_sdiv_seq_step.sv
// sample_sdiv_seq_step: one restoring-division step on magnitudes, purely combinational.
module sample_sdiv_seq_step #(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);
    logic [WIDTH:0] shifted, trial;

    // rem < div (or rem <= |dividend| when div is 0), so the shifted value never overflows WIDTH+1 bits
    assign shifted = {rem, din};
    assign trial   = shifted - {1'b0, div};
    assign qbit    = ~trial[WIDTH];
    assign rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/sample_sdiv_seq.sv
// sample_sdiv_seq: sequential truncating signed divider with ap_* block handshake.
// Define SAMPLE_SDIV_SEQ_REM_EN to add the signed remainder output dout_r.
module sample_sdiv_seq
    import sample_sdiv_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             ap_done,
    output logic [WIDTH-1:0] dout_q,
`ifdef SAMPLE_SDIV_SEQ_REM_EN
    output logic [WIDTH-1:0] dout_r,
`endif
    output logic             dbz,
    output logic             ovf
);
    localparam int CW = clog2(WIDTH);
    localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  qs, dv, rem, rem_nxt, mag0, mag1;
    logic              s0, s1, z, qbit;
    logic [NFLAGS-1:0] flags;

    assign mag0     = din0[WIDTH-1] ? -din0 : din0;
    assign mag1     = din1[WIDTH-1] ? -din1 : din1;
    assign ap_idle  = state == IDLE;
    assign ap_ready = ap_idle & ap_start & ap_rst_n;
    assign ap_done  = state == DONE;
    assign dbz      = flags[FLAG_DBZ];
    assign ovf      = flags[FLAG_OVF];

    sample_sdiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .din    (qs[WIDTH-1]),
        .div    (dv),
        .rem_nxt(rem_nxt),
        .qbit   (qbit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = ap_start ? CALC : IDLE;
            CALC: nxt = (cnt == '0) ? FIX : CALC;
            FIX:  nxt = DONE;
            DONE: nxt = IDLE;
        endcase
    end

    // qs starts as |dividend| and shifts quotient bits in from the LSB as dividend bits leave the MSB
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt    <= '0;
            qs     <= '0;
            dv     <= '0;
            rem    <= '0;
            s0     <= 1'b0;
            s1     <= 1'b0;
            z      <= 1'b0;
            dout_q <= '0;
            flags  <= '0;
`ifdef SAMPLE_SDIV_SEQ_REM_EN
            dout_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (ap_start) begin
                    qs  <= mag0;
                    dv  <= mag1;
                    rem <= '0;
                    s0  <= din0[WIDTH-1];
                    s1  <= din1[WIDTH-1];
                    z   <= din1 == '0;
                    cnt <= CW'(WIDTH - 1);
                end
                CALC: begin
                    qs  <= {qs[WIDTH-2:0], qbit};
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    // MIN / -1 yields magnitude 2^(WIDTH-1), which already wraps to MIN
                    dout_q          <= z ? (s0 ? QMIN : ~QMIN) : ((s0 ^ s1) ? -qs : qs);
                    flags[FLAG_DBZ] <= z;
                    flags[FLAG_OVF] <= s0 & s1 & (dv == WIDTH'(1)) & qs[WIDTH-1];
`ifdef SAMPLE_SDIV_SEQ_REM_EN
                    // with a zero divisor the remainder register ends up holding |dividend|
                    dout_r          <= s0 ? -rem : rem;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_sdiv_seq.sv
// tb_sample_sdiv_seq: directed and randomized checks of sample_sdiv_seq against an
// integer-arithmetic reference model (honours SAMPLE_SDIV_SEQ_REM_EN).
module tb_sample_sdiv_seq;
    localparam int W    = 13;
    localparam int MINV = -(2 ** (W - 1));
    localparam int MAXV = 2 ** (W - 1) - 1;

    logic         ap_clk, ap_rst_n, ap_start;
    logic [W-1:0] din0, din1, dout_q;
    logic         ap_idle, ap_ready, ap_done, dbz, ovf;
`ifdef SAMPLE_SDIV_SEQ_REM_EN
    logic [W-1:0] dout_r;
`endif
    int tests, fails;

    sample_sdiv_seq #(.WIDTH(W)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .din0    (din0),
        .din1    (din1),
        .ap_idle (ap_idle),
        .ap_ready(ap_ready),
        .ap_done (ap_done),
        .dout_q  (dout_q),
`ifdef SAMPLE_SDIV_SEQ_REM_EN
        .dout_r  (dout_r),
`endif
        .dbz     (dbz),
        .ovf     (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b, output int q, output int r,
                                  output bit dz, output bit ov);
        dz = (b == 0);
        ov = (a == MINV) && (b == -1);
        if (dz) begin
            q = (a >= 0) ? MAXV : MINV;
            r = a;
        end else if (ov) begin
            q = MINV;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int rnd13();
        logic signed [W-1:0] v;
        v = W'($urandom);
        return int'(v);
    endfunction

    task automatic chk_res(input int a, input int b);
        int q, r;
        bit dz, ov;
        logic [W-1:0] eq, er;
        model(a, b, q, r, dz, ov);
        eq = q[W-1:0];
        er = r[W-1:0];
        chk("quotient", 32'(dout_q), 32'(eq));
        chk("dbz", 32'(dbz), 32'(dz));
        chk("ovf", 32'(ovf), 32'(ov));
`ifdef SAMPLE_SDIV_SEQ_REM_EN
        chk("remainder", 32'(dout_r), 32'(er));
`else
        if (er === 'x) chk("remainder_x", 32'(er), 0);
`endif
    endtask

    task automatic chk_rst();
        chk("rst_idle", 32'(ap_idle), 1);
        chk("rst_ready", 32'(ap_ready), 0);
        chk("rst_done", 32'(ap_done), 0);
        chk("rst_q", 32'(dout_q), 0);
        chk("rst_dbz", 32'(dbz), 0);
        chk("rst_ovf", 32'(ovf), 0);
`ifdef SAMPLE_SDIV_SEQ_REM_EN
        chk("rst_r", 32'(dout_r), 0);
`endif
    endtask

    // called just after a falling edge; returns just after the falling edge following ap_done
    task automatic do_div(input int a, input int b);
        int k;
        k = 0;
        while (!ap_idle && k < 40) begin
            @(negedge ap_clk);
            k++;
        end
        chk("idle_before", 32'(ap_idle), 1);
        din0 = W'(a);
        din1 = W'(b);
        ap_start = 1'b1;
        #1 chk("ready", 32'(ap_ready), 1);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        k = 1;
        while (!ap_done && k < 40) begin
            @(negedge ap_clk);
            k++;
        end
        chk("latency", k, 15);
        chk_res(a, b);
        @(negedge ap_clk);
        chk("done_pulse", 32'(ap_done), 0);
    endtask

    initial begin
        int qa[$], qb[$];
        int last_ready, ndone, a, b;
        logic [W-1:0] held;
        bit have, pend, seen;
        tests = 0;
        fails = 0;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0 = '0;
        din1 = '0;
        repeat (3) @(negedge ap_clk);
        chk_rst();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        do_div(100, 7);
        do_div(-100, 7);
        do_div(100, -7);
        do_div(-100, -7);
        do_div(MINV, -1);
        do_div(MINV, 1);
        do_div(5, 0);
        do_div(-5, 0);
        do_div(0, 0);
        do_div(MINV, 0);
        do_div(MAXV, MINV);
        do_div(MINV, MINV);
        do_div(MAXV, 1);
        do_div(0, -3);
        do_div(3, 100);

        // ap_start held high: one accept every WIDTH+3 cycles, outputs stable between dones
        last_ready = -1;
        ndone = 0;
        have = 1'b0;
        pend = 1'b0;
        din0 = W'(1234);
        din1 = W'(-11);
        ap_start = 1'b1;
        for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
            if (pend) begin
                din0 = W'(rnd13());
                din1 = W'(rnd13());
                pend = 1'b0;
            end
            #1;
            if (ap_done) begin
                a = qa.pop_front();
                b = qb.pop_front();
                chk_res(a, b);
                held = dout_q;
                have = 1'b1;
                ndone++;
            end else if (have) begin
                chk("hold_q", 32'(dout_q), 32'(held));
            end
            if (ap_ready) begin
                if (last_ready >= 0) chk("ready_spacing", cyc - last_ready, 16);
                last_ready = cyc;
                qa.push_back(int'($signed(din0)));
                qb.push_back(int'($signed(din1)));
                pend = 1'b1;
            end
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        chk("b2b_done_count", ndone, 4);
        @(negedge ap_clk);

        // reset during CALC cycle 6 aborts the operation
        while (!ap_idle) @(negedge ap_clk);
        din0 = W'(1000);
        din1 = W'(3);
        ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (5) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1 chk_rst();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge ap_clk);
            if (ap_done) seen = 1'b1;
        end
        chk("no_done_after_abort", 32'(seen), 0);
        do_div(77, -3);

        for (int i = 0; i < 3000; i++) begin
            a = rnd13();
            b = rnd13();
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = -1;
                2: a = MINV;
                3: b = int'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                default: ;
            endcase
            do_div(a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
